// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that time-shares one fixed-latency Booth multiplier among N_REQ clients.
// Grants one client per operation, drives the multiplier, and returns the product as a one-hot response.
module booth_mul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 4,
    parameter int RW      = 8,
    parameter int MUL_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DW-1:0]   req_a,
    input  logic [N_REQ*DW-1:0]   req_b,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [RW-1:0]         rsp_data,
    output logic                  busy,
    output logic                  err,
    output logic                  mul_start,
    output logic [DW-1:0]         mul_a,
    output logic [DW-1:0]         mul_b,
    input  logic [RW-1:0]         mul_result,
    input  logic                  mul_done,
    output logic [1:0]            dbg_state
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t               state_q;
    logic [PW-1:0]        ptr_q, win_q;
    logic [CW-1:0]        cnt_q;
    logic [N_REQ-1:0]     gnt_q, rsp_valid_q;
    logic [RW-1:0]        rsp_data_q;
    logic                 busy_q, err_q, mul_start_q;
    logic [DW-1:0]        mul_a_q, mul_b_q;

    logic                 found_d;
    logic [PW-1:0]        win_d, ptr_d;
    logic [DW-1:0]        a_d, b_d;
    logic [PW:0]          sum;

    // Search starts at the pointer and wraps, so the last winner has lowest priority next time.
    always_comb begin
        found_d = 1'b0;
        win_d   = '0;
        sum     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
            if (!found_d && req[sum[PW-1:0]]) begin
                found_d = 1'b1;
                win_d   = sum[PW-1:0];
            end
        end
        a_d = '0;
        b_d = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (win_d == PW'(j)) begin
                a_d = req_a[j*DW +: DW];
                b_d = req_b[j*DW +: DW];
            end
        end
        ptr_d = (win_d == PW'(N_REQ-1)) ? '0 : win_d + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            mul_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        gnt_q       <= N_REQ'(1) << win_d;
                        mul_a_q     <= a_d;
                        mul_b_q     <= b_d;
                        ptr_q       <= ptr_d;
                        win_q       <= win_d;
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= CW'(MUL_LAT-1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Count 0 lines up with the multiplier's result becoming valid.
                    if (cnt_q == '0) begin
                        rsp_data_q  <= mul_result;
                        rsp_valid_q <= N_REQ'(1) << win_q;
                        err_q       <= err_q | ~mul_done;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: behavioural multiplier, round-robin reference model,
// expected-product queue and cycle-exact protocol checks.
module tb_booth_mul_arbiter;

    localparam int N_REQ   = 4;
    localparam int DW      = 4;
    localparam int RW      = 8;
    localparam int MUL_LAT = 4;

    logic                clk, rst;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_a, req_b;
    logic [N_REQ-1:0]    gnt, rsp_valid;
    logic [RW-1:0]       rsp_data;
    logic                busy, err, mul_start;
    logic [DW-1:0]       mul_a, mul_b;
    logic [RW-1:0]       mul_result;
    logic                mul_done;
    logic [1:0]          dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    int              m_ptr = 0;
    logic            m_err = 1'b0;
    logic [RW-1:0]   last_rsp = '0;
    logic [RW-1:0]   exp_q[$];
    logic [N_REQ-1:0] req_smp;
    logic            force_bad;

    booth_mul_arbiter #(.N_REQ(N_REQ), .DW(DW), .RW(RW), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .err(err),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_done(mul_done), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural multiplier: result valid MUL_LAT cycles after the start cycle
    int            mm_cnt;
    logic          mm_done;
    logic [RW-1:0] mm_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_cnt  <= 0;
            mm_done <= 1'b0;
            mm_res  <= '0;
        end else if (mul_start) begin
            mm_cnt  <= MUL_LAT - 1;
            mm_done <= 1'b0;
            mm_res  <= RW'(mul_a) * RW'(mul_b);
        end else if (mm_cnt != 0) begin
            mm_cnt <= mm_cnt - 1;
            if (mm_cnt == 1) mm_done <= 1'b1;
        end
    end
    assign mul_result = mm_done ? mm_res : '0;
    assign mul_done   = mm_done & ~force_bad;

    always @(posedge clk) req_smp <= req;

    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int p);
        for (int k = 0; k < N_REQ; k++) begin
            int c;
            c = (p + k) % N_REQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic set_op(input int i, input int a, input int b);
        req_a[i*DW +: DW] = DW'(a);
        req_b[i*DW +: DW] = DW'(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ptr    = 0;
        m_err    = 1'b0;
        last_rsp = '0;
        exp_q.delete();
    endtask

    task automatic wait_gnt(output int owner);
        owner = -1;
        for (int c = 0; c < 20; c++) begin
            if (gnt != '0) begin
                for (int k = 0; k < N_REQ; k++) if (gnt[k] && owner < 0) owner = k;
                break;
            end
            @(negedge clk);
        end
        check("gnt_seen", 32'(owner >= 0), 32'd1);
    endtask

    // One full operation from the grant cycle to the response cycle, checked cycle by cycle.
    task automatic serve(input bit drop, output int owner);
        int               exp_o, o;
        logic [N_REQ-1:0] exp_g;
        logic [DW-1:0]    ea, eb;
        logic [RW-1:0]    exp_p;
        wait_gnt(owner);
        if (owner < 0) return;
        exp_o = rr_pick(req_smp, m_ptr);
        exp_g = (exp_o < 0) ? '0 : N_REQ'(1) << exp_o;
        check("gnt", 32'(gnt), 32'(exp_g));
        if (exp_o >= 0) m_ptr = (exp_o + 1) % N_REQ;
        o  = (exp_o >= 0) ? exp_o : owner;
        ea = req_a[o*DW +: DW];
        eb = req_b[o*DW +: DW];
        exp_q.push_back(RW'(int'(ea) * int'(eb)));
        check("start_pulse", 32'(mul_start), 32'd1);
        check("busy_issue", 32'(busy), 32'd1);
        check("mul_a", 32'(mul_a), 32'(ea));
        check("mul_b", 32'(mul_b), 32'(eb));
        check("err_before", 32'(err), 32'(m_err));
        if (drop) req[owner] = 1'b0;
        repeat (MUL_LAT) begin
            @(negedge clk);
            check("start_low", 32'(mul_start), 32'd0);
            check("busy_wait", 32'(busy), 32'd1);
            check("no_rsp_early", 32'(rsp_valid), 32'd0);
            check("no_gnt_busy", 32'(gnt), 32'd0);
            check("rsp_hold", 32'(rsp_data), 32'(last_rsp));
            check("mul_a_hold", 32'(mul_a), 32'(ea));
        end
        @(negedge clk);
        m_err = m_err | force_bad;
        exp_p = exp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(exp_g));
        check("rsp_data", 32'(rsp_data), 32'(exp_p));
        check("busy_done", 32'(busy), 32'd0);
        check("err", 32'(err), 32'(m_err));
        last_rsp = exp_p;
    endtask

    initial begin
        int o;
        int mask;
        rst = 1'b1; req = '0; req_a = '0; req_b = '0; force_bad = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_start", 32'(mul_start), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        check("rst_mul_b", 32'(mul_b), 32'd0);
        rst = 1'b0;

        // no request: nothing moves
        repeat (3) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_gnt", 32'(gnt), 32'd0);
            check("idle_start", 32'(mul_start), 32'd0);
        end

        // single op on requester 1: 3 x 5
        set_op(1, 3, 5);
        req = 4'b0010;
        serve(1'b1, o);
        check("t1_owner", 32'(o), 32'd1);
        check("t1_product", 32'(rsp_data), 32'd15);

        // boundary operands on requester 3
        set_op(3, 15, 15); req[3] = 1'b1; serve(1'b1, o);
        check("bnd_225", 32'(rsp_data), 32'd225);
        set_op(3, 0, 9);   req[3] = 1'b1; serve(1'b1, o);
        check("bnd_0", 32'(rsp_data), 32'd0);
        set_op(3, 15, 1);  req[3] = 1'b1; serve(1'b1, o);
        check("bnd_15", 32'(rsp_data), 32'd15);
        check("bnd_err", 32'(err), 32'd0);

        // all four held after reset: served 0,1,2,3, products 3,9,15,21
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_op(i, i*2 + 1, 3);
        req = 4'b1111;
        for (int i = 0; i < N_REQ; i++) begin
            serve(1'b1, o);
            check("t2_order", 32'(o), 32'(i));
            check("t2_product", 32'(rsp_data), 32'((i*2 + 1) * 3));
        end

        // fairness: requester 0 held, requester 2 joins a cycle later
        do_reset();
        set_op(0, $urandom_range(0, 15), $urandom_range(0, 15));
        set_op(2, $urandom_range(0, 15), $urandom_range(0, 15));
        req = 4'b0001;
        @(negedge clk);
        req[2] = 1'b1;
        serve(1'b0, o); check("fair_0", 32'(o), 32'd0);
        serve(1'b0, o); check("fair_1", 32'(o), 32'd2);
        serve(1'b1, o); check("fair_2", 32'(o), 32'd0);
        serve(1'b1, o); check("fair_3", 32'(o), 32'd2);

        // randomized masks and operands, each requester dropping at its grant
        for (int r = 0; r < 8; r++) begin
            req_a = (N_REQ*DW)'($urandom);
            req_b = (N_REQ*DW)'($urandom);
            mask  = $urandom_range(1, (1 << N_REQ) - 1);
            req   = N_REQ'(mask);
            for (int g = 0; g < N_REQ && mask != 0; g++) begin
                serve(1'b1, o);
                if (o < 0) break;
                mask = mask & ~(1 << o);
            end
            check("rand_drained", 32'(req), 32'd0);
            req = '0;
        end

        // reset while in WAIT: outputs clear at once, dropped op never responds
        set_op(2, 7, 6);
        req = 4'b0100;
        wait_gnt(o);
        req = '0;
        repeat (2) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_start", 32'(mul_start), 32'd0);
        check("mid_rst_mul_a", 32'(mul_a), 32'd0);
        check("mid_rst_mul_b", 32'(mul_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0; m_err = 1'b0; last_rsp = '0; exp_q.delete();
        repeat (8) begin
            @(negedge clk);
            check("dropped_no_rsp", 32'(rsp_valid), 32'd0);
        end
        req_a = (N_REQ*DW)'($urandom);
        req_b = (N_REQ*DW)'($urandom);
        req = 4'b1111;
        serve(1'b1, o);
        check("post_rst_first", 32'(o), 32'd0);
        for (int i = 1; i < N_REQ; i++) serve(1'b1, o);

        // missing done at capture sets sticky err
        force_bad = 1'b1;
        set_op(1, 9, 9); req[1] = 1'b1; serve(1'b1, o);
        force_bad = 1'b0;
        check("err_set", 32'(err), 32'd1);
        set_op(0, 4, 5); req[0] = 1'b1; serve(1'b1, o);
        set_op(3, 2, 8); req[3] = 1'b1; serve(1'b1, o);
        check("err_sticky", 32'(err), 32'd1);
        do_reset();
        check("err_cleared", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
